d16_top: RTL and testbench
==========================

D16_TOP -- requirements
Module: d16_top

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-low (sampled on the sys_clk rising edge; 0 = reset).
REQ-003 SHALL have port ins_a, output, 16 bits: instruction byte address; the memory returns the word at ins_a[15:2].
REQ-004 SHALL have port ins_di, input, 32 bits: instruction word, valid one cycle after ins_a is presented (synchronous memory).
REQ-005 SHALL have port data_a, output, 16 bits: data byte address; bit 1 selects the half-word (1 = [31:16], 0 = [15:0]); bit 0 is ignored.
REQ-006 SHALL have port data_di, input, 16 bits: load data, valid one cycle after data_a is presented.
REQ-007 SHALL have port data_do, output, 16 bits: store data.
REQ-008 SHALL have port data_we, output, 1 bit: store strobe, active-high, exactly one cycle per STR.

Function
REQ-009 SHALL contain 16 general registers r0..r15, each 16 bits; a register index uses only the low 4 bits of its field.
REQ-010 SHALL decode an instruction as op = [31:24], B2 = [23:16], B1 = [15:8], B0 = [7:0].
REQ-011 SHALL form 16-bit fields little-endian: IMM = {B0,B1}; STRADDR = {B1,B2}; LODADDR = {B0,B1}; JADDR = {B1,B2}.
REQ-012 SHALL use opcodes NOP = 0x00, AFC = 0x01, COP = 0x02, STR = 0x03, LOD = 0x04, JMP = 0x05; any other op SHALL execute as NOP.
REQ-013 AFC: r[B2] <= IMM.
REQ-014 COP: r[B2] <= r[B1].
REQ-015 STR: drive data_a = STRADDR and data_do = r[B0], and assert data_we.
REQ-016 LOD: drive data_a = LODADDR, then r[B2] <= data_di.
REQ-017 JMP: PC <= JADDR.
REQ-018 SHALL be non-pipelined, with a 4-state FSM executing each instruction in exactly 4 cycles: FETCH -> DECODE -> EXEC -> WB -> FETCH.
REQ-019 FETCH: ins_a = PC.
REQ-020 DECODE: IR <= ins_di.
REQ-021 EXEC: read registers; drive the data bus for STR/LOD; data_we = 1 only in EXEC of STR.
REQ-022 WB: register write for AFC, COP and LOD; PC <= PC+4 (16-bit wrap, 0xFFFC -> 0x0000), or JADDR for JMP.
REQ-023 ins_a SHALL equal PC in every state.
REQ-024 data_a and data_do SHALL hold their EXEC values through WB, and until the next STR/LOD EXEC.
REQ-025 data_we SHALL be 0 in all states other than EXEC of a STR.
REQ-026 A register written in WB SHALL be visible to the next instruction; no hazards exist.
REQ-027 r0 is an ordinary writable register.
REQ-028 A JMP to a non-word-aligned address SHALL keep PC as written; the memory ignores bits [1:0].

Reset
REQ-029 While sys_rst = 0 at a rising edge: PC = 0x0000, state = FETCH, IR = 0, r0..r15 = 0x0000, data_we = 0, data_a = 0x0000, data_do = 0x0000.
REQ-030 Reset asserted in any state, including mid-instruction, SHALL abort that instruction with no register write and no further data_we.
REQ-031 Execution SHALL restart with the FETCH of address 0x0000 in the first cycle after sys_rst returns to 1.

Verification
REQ-032 Reset then release -> ins_a = 0x0000, data_we = 0; ins_a advances by 4 every 4 cycles through 0x4, 0x8, 0xC.
REQ-033 AFC words 0x0100AABB, 0x0101BBCC, 0x0102DDEE -> r0 = 0xBBAA, r1 = 0xCCBB, r2 = 0xEEDD.
REQ-034 COP 0x02030200 after those -> r3 = 0xEEDD, with no intervening NOP needed.
REQ-035 STR 0x03001003, then 0x03021003 -> one-cycle data_we with data_a = 0x1000, then 0x1002, data_do = 0xEEDD; memory word 0x400 = 0xEEDDEEDD.
REQ-036 LOD 0x04040110 -> data_a = 0x1001, r4 = 0xEEDD; then JMP 0x05000000 -> ins_a = 0x0000 at the next FETCH.
REQ-037 sys_rst = 0 during EXEC of a STR -> data_we deasserts at that edge, registers return to 0, and the next FETCH is at 0x0000.

Source files
------------

// File: rtl/d16_top.sv
// d16_top: 16-register, 16-bit-datapath processor that runs every instruction in four cycles.
// Instruction and data memories are synchronous, so each read returns data one cycle after its address.
module d16_top (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [15:0] ins_a,
  input  logic [31:0] ins_di,
  output logic [15:0] data_a,
  input  logic [15:0] data_di,
  output logic [15:0] data_do,
  output logic        data_we
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  localparam logic [7:0] OP_AFC = 8'h01;
  localparam logic [7:0] OP_COP = 8'h02;
  localparam logic [7:0] OP_STR = 8'h03;
  localparam logic [7:0] OP_LOD = 8'h04;
  localparam logic [7:0] OP_JMP = 8'h05;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] rf_q [16];
  logic        dwe_q, dwe_d;
  logic [15:0] da_q, da_d;
  logic [15:0] ddo_q, ddo_d;
  logic        rf_we_s;
  logic [3:0]  rf_wa_s;
  logic [15:0] rf_wd_s;

  // The store strobe, address and data are registered at the end of DECODE
  // from the instruction word on ins_di, so they are valid for all of EXEC.
  // The register write and the PC update happen at the end of WB.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    dwe_d   = 1'b0;
    da_d    = da_q;
    ddo_d   = ddo_q;
    rf_we_s = 1'b0;
    rf_wa_s = ir_q[19:16];
    rf_wd_s = 16'h0000;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        ir_d    = ins_di;
        if (ins_di[31:24] == OP_STR) begin
          da_d  = {ins_di[15:8], ins_di[23:16]};
          ddo_d = rf_q[ins_di[3:0]];
          dwe_d = 1'b1;
        end else if (ins_di[31:24] == OP_LOD) begin
          da_d = {ins_di[7:0], ins_di[15:8]};
        end else begin
          dwe_d = 1'b0;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_FETCH;
        if (ir_q[31:24] == OP_JMP) begin
          pc_d = {ir_q[15:8], ir_q[23:16]};
        end else begin
          pc_d = pc_q + 16'd4;
        end
        case (ir_q[31:24])
          OP_AFC: begin
            rf_we_s = 1'b1;
            rf_wd_s = {ir_q[7:0], ir_q[15:8]};
          end
          OP_COP: begin
            rf_we_s = 1'b1;
            rf_wd_s = rf_q[ir_q[11:8]];
          end
          OP_LOD: begin
            rf_we_s = 1'b1;
            rf_wd_s = data_di;
          end
          default: begin
            rf_we_s = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Control state, PC, IR and data bus registers, with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q <= ST_FETCH;
      pc_q    <= 16'h0000;
      ir_q    <= 32'h0000_0000;
      dwe_q   <= 1'b0;
      da_q    <= 16'h0000;
      ddo_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dwe_q   <= dwe_d;
      da_q    <= da_d;
      ddo_q   <= ddo_d;
    end
  end

  // Register file: cleared on reset, with one write port used in WB.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else if (rf_we_s) begin
      rf_q[rf_wa_s] <= rf_wd_s;
    end else begin
      rf_q[rf_wa_s] <= rf_q[rf_wa_s];
    end
  end

  assign ins_a   = pc_q;
  assign data_a  = da_q;
  assign data_do = ddo_q;
  assign data_we = dwe_q;

endmodule

// File: tb/tb_d16_top.sv
// Directed testbench for d16_top, with behavioural synchronous instruction and data memories.
module tb_d16_top;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [15:0] ins_a;
  logic [31:0] ins_di;
  logic [15:0] data_a;
  logic [15:0] data_di;
  logic [15:0] data_do;
  logic        data_we;

  logic [31:0] imem [64];
  logic [31:0] dmem [16384];
  int checks = 0;
  int failures = 0;

  d16_top dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ins_a(ins_a), .ins_di(ins_di),
    .data_a(data_a), .data_di(data_di),
    .data_do(data_do), .data_we(data_we)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous memories with one cycle of read latency; stores write a half-word.
  always @(posedge sys_clk) begin
    ins_di  <= imem[ins_a[7:2]];
    data_di <= data_a[1] ? dmem[data_a[15:2]][31:16] : dmem[data_a[15:2]][15:0];
    if (data_we) begin
      if (data_a[1]) dmem[data_a[15:2]][31:16] <= data_do;
      else           dmem[data_a[15:2]][15:0]  <= data_do;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_da;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
    for (int i = 0; i < 16384; i++) dmem[i] = 32'h0000_0000;
    imem[0] = 32'h0100_AABB;
    imem[1] = 32'h0101_BBCC;
    imem[2] = 32'h0102_DDEE;
    imem[3] = 32'h0203_0200;
    imem[4] = 32'h0300_1003;
    imem[5] = 32'h0302_1003;
    imem[6] = 32'h0404_0110;
    imem[7] = 32'h0500_0000;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_ins_a", {16'h0, ins_a}, 32'h0000_0000);
    chk("rst_we", {31'h0, data_we}, 32'h0);
    chk("rst_data_a", {16'h0, data_a}, 32'h0);
    chk("rst_data_do", {16'h0, data_do}, 32'h0);
    chk("rst_r0", {16'h0, dut.rf_q[0]}, 32'h0);

    // Program run: cycle k=0 is the first FETCH after reset release
    sys_rst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k >= 26)      exp_da = 16'h1001;
      else if (k >= 22) exp_da = 16'h1002;
      else if (k >= 18) exp_da = 16'h1000;
      else              exp_da = 16'h0000;
      chk($sformatf("ins_a_k%0d", k), {16'h0, ins_a}, 32'(4 * (k / 4)));
      chk($sformatf("we_k%0d", k), {31'h0, data_we}, {31'h0, (k == 18 || k == 22)});
      chk($sformatf("data_a_k%0d", k), {16'h0, data_a}, {16'h0, exp_da});
      chk($sformatf("data_do_k%0d", k), {16'h0, data_do}, (k >= 18) ? 32'h0000_EEDD : 32'h0);
      @(negedge sys_clk);
    end
    // k=32: FETCH that follows the JMP
    chk("jmp_ins_a", {16'h0, ins_a}, 32'h0000_0000);
    chk("r0", {16'h0, dut.rf_q[0]}, 32'h0000_BBAA);
    chk("r1", {16'h0, dut.rf_q[1]}, 32'h0000_CCBB);
    chk("r2", {16'h0, dut.rf_q[2]}, 32'h0000_EEDD);
    chk("r3", {16'h0, dut.rf_q[3]}, 32'h0000_EEDD);
    chk("r4", {16'h0, dut.rf_q[4]}, 32'h0000_EEDD);
    chk("mem_400", dmem[14'h0400], 32'hEEDD_EEDD);

    // Second pass: assert reset during EXEC of the first STR (k=32+18)
    repeat (18) @(negedge sys_clk);
    chk("str2_we", {31'h0, data_we}, 32'h1);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_we", {31'h0, data_we}, 32'h0);
    chk("abort_ins_a", {16'h0, ins_a}, 32'h0);
    chk("abort_data_a", {16'h0, data_a}, 32'h0);
    chk("abort_r0", {16'h0, dut.rf_q[0]}, 32'h0);
    chk("abort_r4", {16'h0, dut.rf_q[4]}, 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    chk("restart_ins_a0", {16'h0, ins_a}, 32'h0);
    repeat (4) @(negedge sys_clk);
    chk("restart_ins_a4", {16'h0, ins_a}, 32'h0000_0004);

    // Unaligned JMP, jump to 0xFFFC, PC wrap, and an unknown opcode that must act as NOP
    sys_rst = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
    imem[0]  = 32'h0522_0000;
    imem[8]  = 32'h05FC_FF00;
    imem[63] = 32'hFF05_AAAA;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    chk("p3_ins_a0", {16'h0, ins_a}, 32'h0);
    repeat (4) @(negedge sys_clk);
    chk("unaligned_jmp", {16'h0, ins_a}, 32'h0000_0022);
    repeat (4) @(negedge sys_clk);
    chk("jmp_fffc", {16'h0, ins_a}, 32'h0000_FFFC);
    repeat (4) @(negedge sys_clk);
    chk("pc_wrap", {16'h0, ins_a}, 32'h0000_0000);
    chk("badop_r5", {16'h0, dut.rf_q[5]}, 32'h0);
    chk("badop_we", {31'h0, data_we}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
